// File: rtl/truth_table_sweeper.sv
// ============================================================================
//  Module   : truth_table_sweeper
//  Purpose  : Drives all eight rows of a 3-input netlist, captures its output
//             and compares the resulting truth table against EXPECTED.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter logic [7:0]  EXPECTED = 8'h49,
  parameter int unsigned SETTLE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [7:0] mismatch
);

  // SETTLE of 0 is treated as 1, so the reload value bottoms out at 0.
  localparam logic [7:0] c_RELOAD = (SETTLE <= 1) ? 8'd0 : 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_row;
  logic [7:0] r_cnt;
  logic [7:0] r_captured;
  logic [7:0] r_mismatch;
  logic       r_pass;
  logic       r_done;
  logic       w_sample;
  logic       w_last;

  assign w_sample = (r_state == S_APPLY) && (r_cnt == 8'd0);
  assign w_last   = w_sample && (r_row == 3'd7);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_APPLY;
      S_APPLY: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= 3'd0;
      r_cnt      <= 8'd0;
      r_captured <= 8'd0;
      r_mismatch <= 8'd0;
      r_pass     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row      <= 3'd0;
            r_cnt      <= c_RELOAD;
            r_captured <= 8'd0;
            r_mismatch <= 8'd0;
            r_pass     <= 1'b0;
          end
        end
        S_APPLY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Row 0 lands in the MSB of the captured table.
            r_captured[3'd7 - r_row] <= dut_out;
            if (r_row == 3'd7) begin
              r_row <= 3'd0;
            end else begin
              r_row <= r_row + 3'd1;
              r_cnt <= c_RELOAD;
            end
          end
        end
        S_DONE: begin
          r_mismatch <= r_captured ^ EXPECTED;
          r_pass     <= (r_captured == EXPECTED);
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {in1, in2, in3} = r_row;
  assign busy            = (r_state == S_APPLY);
  assign done            = r_done;
  assign pass            = r_pass;
  assign captured        = r_captured;
  assign mismatch        = r_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
//  Module   : tb_truth_table_sweeper
//  Purpose  : Self-checking bench driving two sweepers (SETTLE 4 and 1) with a
//             behavioural netlist model on dut_out.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       sel;
  int         mode;
  logic [7:0] tbl;
  int         checks = 0;
  int         errors = 0;

  logic       a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_dout;
  logic [7:0] a_cap, a_mis;
  logic       b_in1, b_in2, b_in3, b_busy, b_done, b_pass, b_dout;
  logic [7:0] b_cap, b_mis;

  // Netlist under test: 0 good, 1 stuck-0, 2 stuck-1, 3 row 5 inverted, 4 table tbl
  function automatic logic model_out(input logic [2:0] r, input int m, input logic [7:0] t);
    logic a, b, c, good;
    {a, b, c} = r;
    good = (a & (b ~^ c)) | (~a & ~b & c);
    case (m)
      0:       return good;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return good ^ (r == 3'd5);
      default: return t[3'd7 - r];
    endcase
  endfunction

  function automatic logic [7:0] exp_table(input int m, input logic [7:0] t);
    logic [7:0] e;
    e = 8'd0;
    for (int i = 0; i < 8; i++) e[7 - i] = model_out(3'(i), m, t);
    return e;
  endfunction

  assign a_dout = model_out({a_in1, a_in2, a_in3}, mode, tbl);
  assign b_dout = model_out({b_in1, b_in2, b_in3}, mode, tbl);

  truth_table_sweeper #(.EXPECTED(8'h49), .SETTLE(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .dut_out(a_dout),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
    .pass(a_pass), .captured(a_cap), .mismatch(a_mis)
  );

  truth_table_sweeper #(.EXPECTED(8'h49), .SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .dut_out(b_dout),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
    .pass(b_pass), .captured(b_cap), .mismatch(b_mis)
  );

  logic [2:0] v_row;
  logic       v_busy, v_done, v_pass;
  logic [7:0] v_cap, v_mis;
  assign v_row  = sel ? {b_in1, b_in2, b_in3} : {a_in1, a_in2, a_in3};
  assign v_busy = sel ? b_busy : a_busy;
  assign v_done = sel ? b_done : a_done;
  assign v_pass = sel ? b_pass : a_pass;
  assign v_cap  = sel ? b_cap  : a_cap;
  assign v_mis  = sel ? b_mis  : a_mis;

  task automatic do_sweep(input string name, input logic [7:0] ecap, input bit repulse);
    int s, n, first_done, ndone, nbusy, badrow, badclr;
    logic [2:0] erow;
    s = sel ? 1 : 4;
    n = 8 * s;
    first_done = -1; ndone = 0; nbusy = 0; badrow = 0; badclr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= n + 3; k++) begin
      if (k > 0) @(negedge clk);
      start = repulse && (k == 5 || k == 20);
      erow = (k < n) ? 3'(k / s) : 3'd0;
      if (v_row !== erow) badrow++;
      if (v_busy) nbusy++;
      if (v_done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (k == 0 && (v_cap !== 8'd0 || v_mis !== 8'd0 || v_pass !== 1'b0)) badclr++;
      if (k == n + 1) begin
        checks++;
        if (v_cap !== ecap) begin
          errors++; $display("FAIL %s_captured: got %h expected %h", name, v_cap, ecap);
        end
        checks++;
        if (v_mis !== (ecap ^ 8'h49)) begin
          errors++; $display("FAIL %s_mismatch: got %h expected %h", name, v_mis, ecap ^ 8'h49);
        end
        checks++;
        if (v_pass !== (ecap == 8'h49)) begin
          errors++; $display("FAIL %s_pass: got %b expected %b", name, v_pass, ecap == 8'h49);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (badrow !== 0) begin
      errors++; $display("FAIL %s_rows: got %0d bad row cycles expected 0", name, badrow);
    end
    checks++;
    if (nbusy !== n) begin
      errors++; $display("FAIL %s_busy_len: got %0d expected %0d", name, nbusy, n);
    end
    checks++;
    if (first_done !== n + 1) begin
      errors++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, first_done, n + 1);
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL %s_done_count: got %0d expected 1", name, ndone);
    end
    checks++;
    if (badclr !== 0) begin
      errors++; $display("FAIL %s_clear_on_start: got %0d bad expected 0", name, badclr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; mode = 0; tbl = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_cap, a_mis} !== 22'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0",
                         {a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_cap, a_mis});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct();
    sel = 1'b0; mode = 0;
    do_sweep("correct", 8'h49, 1'b0);
  endtask

  task automatic test_stuck();
    sel = 1'b0; mode = 1;
    do_sweep("stuck0", 8'h00, 1'b0);
    mode = 2;
    do_sweep("stuck1", 8'hFF, 1'b0);
  endtask

  task automatic test_settle1();
    sel = 1'b1; mode = 0;
    do_sweep("settle1", 8'h49, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_restart_ignored();
    sel = 1'b0; mode = 0;
    do_sweep("repulse", 8'h49, 1'b1);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0; mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_cap, a_mis} !== 22'd0) begin
      errors++; $display("FAIL midreset_async: got %h expected 0",
                         {a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_cap, a_mis});
    end
    @(negedge clk); rst_n = 1'b1;
    do_sweep("after_reset", 8'h49, 1'b0);
  endtask

  task automatic test_row5();
    logic [7:0] held;
    sel = 1'b0; mode = 3;
    do_sweep("row5", 8'h4D, 1'b0);
    held = v_cap;
    repeat (10) @(negedge clk);
    checks++;
    if (v_cap !== 8'h4D || v_mis !== 8'h04 || v_pass !== 1'b0) begin
      errors++; $display("FAIL row5_hold: got cap %h mis %h pass %b expected 4d 04 0",
                         v_cap, v_mis, v_pass);
    end
  endtask

  task automatic test_back_to_back();
    int n, d1, d2, ndone, gap_bad;
    sel = 1'b0; mode = 0; n = 32; d1 = -1; d2 = -1; ndone = 0; gap_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 2 * n + 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2 * n + 2) start = 1'b0;
      if (a_done) begin
        ndone++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == n + 1 && (a_busy !== 1'b0 || {a_in1, a_in2, a_in3} !== 3'd0)) gap_bad++;
      if (k == n + 2 && a_busy !== 1'b1) gap_bad++;
    end
    checks++;
    if (d1 !== n + 1 || d2 !== 2 * n + 3 || ndone !== 2) begin
      errors++; $display("FAIL b2b_done: got %0d,%0d (%0d pulses) expected %0d,%0d (2)",
                         d1, d2, ndone, n + 1, 2 * n + 3);
    end
    checks++;
    if (gap_bad !== 0) begin
      errors++; $display("FAIL b2b_gap: got %0d bad expected 0", gap_bad);
    end
    checks++;
    if (a_pass !== 1'b1 || a_cap !== 8'h49) begin
      errors++; $display("FAIL b2b_result: got pass %b cap %h expected 1 49", a_pass, a_cap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      sel = 1'(i % 2); mode = 4; tbl = 8'($urandom);
      do_sweep($sformatf("rand%0d", i), exp_table(mode, tbl), 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck();
    test_settle1();
    test_restart_ignored();
    test_mid_reset();
    test_row5();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
